to_serial: RTL and testbench

TO_SERIAL -- requirements
Module: to_serial

---
 rtl/to_serial_if.sv | 24 ++
 rtl/to_serial.sv | 112 +++++++++++
 tb/tb_to_serial.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/to_serial_if.sv
// Parallel-word in / serial-chunk out stream bundle for to_serial.
// The master drives words in and observes the chunk stream. The slave is the serializer.
interface to_serial_if #(
  parameter int NO_CH    = 10,
  parameter int BW_WORD  = 8,
  parameter int BW_CHUNK = 2
);
  logic                              vld_in;
  logic [NO_CH-1:0][BW_WORD-1:0]     data_in;
  logic                              rdy_in;
  logic                              vld_out;
  logic                              sof_out;
  logic [NO_CH-1:0][BW_CHUNK-1:0]    data_out;

  modport master (
    output vld_in, data_in,
    input  rdy_in, vld_out, sof_out, data_out
  );

  modport slave (
    input  vld_in, data_in,
    output rdy_in, vld_out, sof_out, data_out
  );
endinterface

// File: rtl/to_serial.sv
// Multi-channel parallel-to-serial converter.
// Each channel's word is emitted LSB chunk first, one chunk per cycle.
// A one-word pending buffer lets the next word be taken while the current word
// is still shifting out. This keeps back-to-back words gap-free.
module to_serial #(
  parameter int NO_CH    = 10,
  parameter int BW_WORD  = 8,
  parameter int BW_CHUNK = 2
) (
  input  logic        clk,
  input  logic        rst,
  to_serial_if.slave  bus
);
  localparam int NO_CYC = BW_WORD / BW_CHUNK;
  localparam int CNT_W  = ($clog2(NO_CYC) > 1) ? $clog2(NO_CYC) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NO_CYC - 1);

  typedef logic [NO_CH-1:0][BW_WORD-1:0]  word_t;
  typedef logic [NO_CH-1:0][BW_CHUNK-1:0] chunk_t;

  // Drop the chunk just emitted from every channel independently.
  function automatic word_t shift_chunk(input word_t w);
    word_t r;
    for (int ch = 0; ch < NO_CH; ch++) begin
      r[ch] = w[ch] >> BW_CHUNK;
    end
    return r;
  endfunction

  // Current chunk of every channel is the low slice of its shift lane.
  function automatic chunk_t low_chunk(input word_t w);
    chunk_t r;
    for (int ch = 0; ch < NO_CH; ch++) begin
      r[ch] = w[ch][BW_CHUNK-1:0];
    end
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  word_t            sh_q, sh_d;
  word_t            pend_q, pend_d;

  logic rdy;
  logic xfer;
  logic last;

  // Acceptance depends only on the pending buffer being free, never on vld_in.
  assign rdy  = !pend_vld_q;
  assign xfer = bus.vld_in && rdy;
  assign last = (cnt_q == CNT_LAST);

  // Next-state: load, shift, pending hand-off and return to idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    sh_d       = sh_q;
    pend_d     = pend_q;
    if (state_q == ST_IDLE) begin
      if (xfer) begin
        sh_d    = bus.data_in;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
    end else if (!last) begin
      sh_d  = shift_chunk(sh_q);
      cnt_d = cnt_q + CNT_W'(1);
      if (xfer) begin
        pend_d     = bus.data_in;
        pend_vld_d = 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (pend_vld_q) begin
        sh_d       = pend_q;
        pend_vld_d = 1'b0;
      end else if (xfer) begin
        sh_d = bus.data_in;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; reset also discards any active or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      sh_q       <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.rdy_in   = rdy;
  assign bus.vld_out  = (state_q == ST_SHIFT);
  assign bus.sof_out  = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign bus.data_out = (state_q == ST_SHIFT) ? low_chunk(sh_q) : '0;
endmodule

// File: tb/tb_to_serial.sv
// Bench for to_serial with 2 channels, 8-bit words and 2-bit chunks.
// The reference model schedules every accepted word onto an expected
// per-cycle output timeline. A word starts one cycle after acceptance, or as
// soon as the previous word ends if that is later. A word waits in the pending
// slot from acceptance until its start cycle, and rdy_in is low during that wait.
// A 2->8 MSB-inserting deserializer on the output also rebuilds the words and
// compares them in order against the accepted-word queue.
module tb_to_serial;
  localparam int NO_CH  = 2;
  localparam int BW_W   = 8;
  localparam int BW_C   = 2;
  localparam int NCYC   = BW_W / BW_C;
  localparam int MAXC   = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  to_serial_if #(.NO_CH(NO_CH), .BW_WORD(BW_W), .BW_CHUNK(BW_C)) bus ();

  to_serial #(.NO_CH(NO_CH), .BW_WORD(BW_W), .BW_CHUNK(BW_C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit exp_vld  [MAXC];
  bit exp_sof  [MAXC];
  bit exp_pend [MAXC];
  int exp_dat  [MAXC];

  int t        = 0;
  int prev_end = 0;
  bit chk_on   = 1'b0;

  int          lb_q [$];
  logic [7:0]  acc0, acc1;
  int          dcnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, t, obs, exp);
    end
  endtask

  // One clock cycle: check outputs for cycle t, drive inputs, advance the model.
  task automatic step(input bit r, input bit v, input logic [7:0] d0,
                      input logic [7:0] d1, output bit acc);
    int s;
    int w;
    @(negedge clk);
    if (chk_on) begin
      chk("vld_out",  int'(bus.vld_out),  int'(exp_vld[t]));
      chk("sof_out",  int'(bus.sof_out),  int'(exp_sof[t]));
      chk("data_out", int'(bus.data_out), exp_dat[t]);
      chk("rdy_in",   int'(bus.rdy_in),   int'(!exp_pend[t]));
      if (bus.vld_out) begin
        if (bus.sof_out) dcnt = 0;
        acc0 = {bus.data_out[0], acc0[7:2]};
        acc1 = {bus.data_out[1], acc1[7:2]};
        dcnt++;
        if (dcnt == NCYC) begin
          dcnt = 0;
          chk("lb_avail", int'(lb_q.size() > 0), 1);
          if (lb_q.size() > 0) begin
            w = lb_q.pop_front();
            chk("lb_word", int'({acc1, acc0}), w);
          end
        end
      end
    end
    rst         = r;
    bus.vld_in  = v;
    bus.data_in = {d1, d0};
    acc = 1'b0;
    if (r) begin
      for (int i = t + 1; i < MAXC && i <= t + 16; i++) begin
        exp_vld[i] = 0; exp_sof[i] = 0; exp_pend[i] = 0; exp_dat[i] = 0;
      end
      prev_end = t + 1;
      lb_q.delete();
      dcnt   = 0;
      chk_on = 1'b1;
    end else if (v && !exp_pend[t]) begin
      acc = 1'b1;
      s = (t + 1 > prev_end) ? t + 1 : prev_end;
      for (int k = 0; k < NCYC; k++) begin
        exp_vld[s+k] = 1;
        exp_sof[s+k] = (k == 0);
        exp_dat[s+k] = (((int'(d1) >> (BW_C*k)) & 3) << 2) | ((int'(d0) >> (BW_C*k)) & 3);
      end
      for (int i = t + 1; i < s; i++) exp_pend[i] = 1;
      prev_end = s + NCYC;
      lb_q.push_back(int'({d1, d0}));
    end
    @(posedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, a);
  endtask

  initial begin
    bit a;
    int idx;
    logic [7:0] wl [3];
    for (int i = 0; i < MAXC; i++) begin
      exp_vld[i] = 0; exp_sof[i] = 0; exp_pend[i] = 0; exp_dat[i] = 0;
    end
    acc0 = '0; acc1 = '0;
    rst = 1'b1; bus.vld_in = 1'b0; bus.data_in = '0;

    // Reset, then a single word from idle.
    step(1, 0, 8'h00, 8'h00, a);
    step(1, 1, 8'hAA, 8'h55, a);
    idle(2);
    step(0, 1, 8'hB4, 8'h1E, a);
    idle(7);

    // Sustained vld_in with three words.
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33;
    idx = 0;
    while (idx < 3) begin
      step(0, 1, wl[idx], wl[idx], a);
      if (a) idx++;
    end
    idle(14);

    // Second word offered on chunk 1, then 0xFF held while rdy_in is low.
    step(0, 1, 8'hC6, 8'h39, a);
    step(0, 0, 8'h00, 8'h00, a);
    step(0, 1, 8'h5A, 8'hA5, a);
    step(0, 1, 8'hFF, 8'hFF, a);
    step(0, 1, 8'hFF, 8'hFF, a);
    idle(8);

    // Reset during chunk 2 with a word pending.
    step(0, 1, 8'h3C, 8'hC3, a);
    step(0, 0, 8'h00, 8'h00, a);
    step(0, 1, 8'h96, 8'h69, a);
    step(1, 0, 8'h00, 8'h00, a);
    idle(8);

    // Random traffic with occasional resets.
    while (t < MAXC - 40) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
           8'($urandom), 8'($urandom), a);
    end
    idle(12);
    chk("lb_drain", lb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
